// File: rtl/hms_timer.sv
// Hours/minutes/seconds timekeeper: one-second prescaler, up/down counting, preset load,
// edge-triggered adjust and a pipelined decimal-packed hhmmss output.
module hms_timer #(
    parameter int unsigned T_HOLD       = 100_000_000,
    parameter int unsigned T_HOLD_WIDTH = $clog2(T_HOLD),
    parameter int unsigned HOURS_MAX    = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        count_down,
    input  logic        adjust_minutes,
    input  logic        adjust_hours,
    input  logic        load,
    input  logic [7:0]  load_h,
    input  logic [7:0]  load_m,
    input  logic [7:0]  load_s,
    output logic [7:0]  hours,
    output logic [7:0]  minutes,
    output logic [7:0]  seconds,
    output logic        tick,
    output logic        expired,
    output logic [23:0] o_number
);

    localparam logic [T_HOLD_WIDTH-1:0] PrescLast  = T_HOLD_WIDTH'(T_HOLD - 1);
    localparam logic [7:0]              HourLast   = 8'(HOURS_MAX - 1);
    localparam logic [7:0]              MinSecLast = 8'd59;

    typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

    state_e                  state_q, state_d;
    logic [T_HOLD_WIDTH-1:0] presc_q, presc_d;
    logic                    pend_q, pend_d;
    logic                    adj_m_q, adj_h_q;
    logic [7:0]              hours_q, hours_d;
    logic [7:0]              minutes_q, minutes_d;
    logic [7:0]              seconds_q, seconds_d;
    logic                    tick_q, tick_d;
    logic                    expired_q, expired_d;

    logic       rise_m, rise_h;
    logic       presc_wrap, tick_avail, time_zero, hit_done;
    logic [7:0] ld_h, ld_m, ld_s;

    // Display pipeline registers
    logic [13:0] st1_h100_q;
    logic [12:0] st1_m100_q;
    logic [7:0]  st1_s_q;
    logic [19:0] st2_h10000_q;
    logic [12:0] st2_ms_q;
    logic [19:0] st3_sum_q;

    always_comb begin
        rise_m     = adjust_minutes & ~adj_m_q;
        rise_h     = adjust_hours & ~adj_h_q;
        presc_wrap = (presc_q == PrescLast);
        // A pending tick survives only while counting; IDLE and DONE discard it.
        tick_avail = (presc_wrap | pend_q) & (state_q == StCount);
        time_zero  = (hours_q == 8'd0) && (minutes_q == 8'd0) && (seconds_q == 8'd0);

        ld_h = (load_h > HourLast)   ? HourLast   : load_h;
        ld_m = (load_m > MinSecLast) ? MinSecLast : load_m;
        ld_s = (load_s > MinSecLast) ? MinSecLast : load_s;

        state_d   = state_q;
        presc_d   = presc_wrap ? '0 : presc_q + T_HOLD_WIDTH'(1);
        pend_d    = 1'b0;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        tick_d    = 1'b0;
        expired_d = 1'b0;
        hit_done  = 1'b0;

        if (load) begin
            hours_d   = ld_h;
            minutes_d = ld_m;
            seconds_d = ld_s;
            presc_d   = '0;
        end else if (rise_m || rise_h) begin
            if (rise_m) begin
                minutes_d = (minutes_q == MinSecLast) ? 8'd0 : minutes_q + 8'd1;
            end
            if (rise_h) begin
                hours_d = (hours_q == HourLast) ? 8'd0 : hours_q + 8'd1;
            end
            pend_d = tick_avail;
        end else if (tick_avail) begin
            if (!count_down) begin
                tick_d = 1'b1;
                if (seconds_q == MinSecLast) begin
                    seconds_d = 8'd0;
                    if (minutes_q == MinSecLast) begin
                        minutes_d = 8'd0;
                        hours_d   = (hours_q == HourLast) ? 8'd0 : hours_q + 8'd1;
                    end else begin
                        minutes_d = minutes_q + 8'd1;
                    end
                end else begin
                    seconds_d = seconds_q + 8'd1;
                end
            end else if (time_zero) begin
                hit_done = 1'b1;
            end else begin
                tick_d = 1'b1;
                if (seconds_q == 8'd0) begin
                    seconds_d = MinSecLast;
                    if (minutes_q == 8'd0) begin
                        minutes_d = MinSecLast;
                        hours_d   = hours_q - 8'd1;
                    end else begin
                        minutes_d = minutes_q - 8'd1;
                    end
                end else begin
                    seconds_d = seconds_q - 8'd1;
                end
                if ((hours_q == 8'd0) && (minutes_q == 8'd0) && (seconds_q == 8'd1)) begin
                    expired_d = 1'b1;
                    hit_done  = 1'b1;
                end
            end
        end

        if (load) begin
            state_d = run ? StCount : StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (run) state_d = StCount;
                end
                StCount: begin
                    if (!run) begin
                        state_d = StIdle;
                    end else if (hit_done) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (!run) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            pend_q    <= 1'b0;
            adj_m_q   <= 1'b0;
            adj_h_q   <= 1'b0;
            hours_q   <= 8'd0;
            minutes_q <= 8'd0;
            seconds_q <= 8'd0;
            tick_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            pend_q    <= pend_d;
            adj_m_q   <= adjust_minutes;
            adj_h_q   <= adjust_hours;
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            seconds_q <= seconds_d;
            tick_q    <= tick_d;
            expired_q <= expired_d;
        end
    end

    // Fields never exceed 99 hours / 59 minutes, so the narrowed products cannot overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st1_h100_q   <= '0;
            st1_m100_q   <= '0;
            st1_s_q      <= '0;
            st2_h10000_q <= '0;
            st2_ms_q     <= '0;
            st3_sum_q    <= '0;
        end else begin
            st1_h100_q   <= 14'(hours_q) * 14'd100;
            st1_m100_q   <= 13'(minutes_q) * 13'd100;
            st1_s_q      <= seconds_q;
            st2_h10000_q <= 20'(st1_h100_q) * 20'd100;
            st2_ms_q     <= st1_m100_q + 13'(st1_s_q);
            st3_sum_q    <= st2_h10000_q + 20'(st2_ms_q);
        end
    end

    assign hours    = hours_q;
    assign minutes  = minutes_q;
    assign seconds  = seconds_q;
    assign tick     = tick_q;
    assign expired  = expired_q;
    assign o_number = {4'b0000, st3_sum_q};

endmodule

// File: tb/tb_hms_timer.sv
// Self-checking bench for hms_timer: directed scenarios plus randomized stimulus
// compared against a total-seconds reference model.
module tb_hms_timer;

    localparam int THOLD = 4;
    localparam int HM    = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        count_down = 1'b0;
    logic        adjust_minutes = 1'b0;
    logic        adjust_hours = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  load_h = 8'd0;
    logic [7:0]  load_m = 8'd0;
    logic [7:0]  load_s = 8'd0;
    logic [7:0]  hours, minutes, seconds;
    logic        tick, expired;
    logic [23:0] o_number;
    logic [7:0]  h12, m12, s12;
    logic        tick12, exp12;
    logic [23:0] onum12;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    hms_timer #(.T_HOLD(THOLD), .HOURS_MAX(HM)) dut (
        .clk(clk), .rst(rst), .run(run), .count_down(count_down),
        .adjust_minutes(adjust_minutes), .adjust_hours(adjust_hours), .load(load),
        .load_h(load_h), .load_m(load_m), .load_s(load_s),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .tick(tick), .expired(expired), .o_number(o_number)
    );

    hms_timer #(.T_HOLD(THOLD), .HOURS_MAX(12)) dut12 (
        .clk(clk), .rst(rst), .run(run), .count_down(count_down),
        .adjust_minutes(adjust_minutes), .adjust_hours(adjust_hours), .load(load),
        .load_h(load_h), .load_m(load_m), .load_s(load_s),
        .hours(h12), .minutes(m12), .seconds(s12),
        .tick(tick12), .expired(exp12), .o_number(onum12)
    );

    // Reference model: time kept as total seconds since midnight.
    int m_secs, m_presc, m_mode, m_onum;
    bit m_pend, m_pam, m_pah, m_tick, m_exp;
    int m_hist[$];

    function automatic int clampv(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int packed_dec(int secs);
        return (secs / 3600) * 10000 + ((secs / 60) % 60) * 100 + (secs % 60);
    endfunction

    task automatic model_reset();
        m_secs = 0; m_presc = 0; m_mode = 0; m_pend = 0;
        m_pam = 0; m_pah = 0; m_tick = 0; m_exp = 0; m_onum = 0;
        m_hist.delete();
        repeat (3) m_hist.push_back(0);
    endtask

    // mode: 0 idle, 1 count, 2 done
    task automatic model_step();
        bit rise_m, rise_h, tick_int, avail, hit_done;
        int h, m, s, next_mode;
        rise_m   = adjust_minutes && !m_pam;
        rise_h   = adjust_hours && !m_pah;
        tick_int = (m_presc == THOLD - 1);
        avail    = (tick_int || m_pend) && (m_mode == 1);
        hit_done = 0;
        m_tick   = 0;
        m_exp    = 0;
        next_mode = m_mode;
        if (load) begin
            m_secs = clampv(int'(load_h), HM - 1) * 3600 + clampv(int'(load_m), 59) * 60
                     + clampv(int'(load_s), 59);
            m_presc = 0;
            m_pend = 0;
            next_mode = run ? 1 : 0;
        end else begin
            m_presc = tick_int ? 0 : m_presc + 1;
            if (rise_m || rise_h) begin
                h = m_secs / 3600; m = (m_secs / 60) % 60; s = m_secs % 60;
                if (rise_m) m = (m + 1) % 60;
                if (rise_h) h = (h + 1) % HM;
                m_secs = h * 3600 + m * 60 + s;
                m_pend = avail;
            end else begin
                m_pend = 0;
                if (avail) begin
                    if (!count_down) begin
                        m_secs = (m_secs + 1) % (HM * 3600);
                        m_tick = 1;
                    end else if (m_secs == 0) begin
                        hit_done = 1;
                    end else begin
                        m_secs = m_secs - 1;
                        m_tick = 1;
                        if (m_secs == 0) begin
                            m_exp = 1;
                            hit_done = 1;
                        end
                    end
                end
            end
            if (m_mode == 0 && run) next_mode = 1;
            else if (m_mode == 1 && !run) next_mode = 0;
            else if (m_mode == 1 && hit_done) next_mode = 2;
            else if (m_mode == 2 && !run) next_mode = 0;
        end
        m_mode = next_mode;
        m_pam = adjust_minutes;
        m_pah = adjust_hours;
        m_hist.push_back(packed_dec(m_secs));
        m_onum = m_hist.pop_front();
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int h, input int m, input int s);
        load_h = 8'(h); load_m = 8'(m); load_s = 8'(s);
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (hours !== 8'd0 || minutes !== 8'd0 || seconds !== 8'd0) begin
            $display("FAIL reset_time: got %0d:%0d:%0d, want 0:0:0", hours, minutes, seconds);
        end else passed++;
        total++;
        if (tick !== 1'b0 || expired !== 1'b0) begin
            $display("FAIL reset_pulses: got tick=%b expired=%b, want 0 0", tick, expired);
        end else passed++;
        total++;
        if (o_number !== 24'd0) begin
            $display("FAIL reset_number: got %0d, want 0", o_number);
        end else passed++;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_count_up();
        run = 1'b1; count_down = 1'b0;
        do_load(0, 0, 58);
        repeat (3) step();
        total++;
        if (tick !== 1'b0 || seconds !== 8'd58) begin
            $display("FAIL up_pre_tick: got tick=%b s=%0d, want 0 58", tick, seconds);
        end else passed++;
        step();
        total++;
        if (tick !== 1'b1 || seconds !== 8'd59 || minutes !== 8'd0) begin
            $display("FAIL up_tick1: got tick=%b %0d:%0d, want 1 0:59", tick, minutes, seconds);
        end else passed++;
        repeat (4) step();
        total++;
        if (tick !== 1'b1 || hours !== 8'd0 || minutes !== 8'd1 || seconds !== 8'd0) begin
            $display("FAIL up_carry: got tick=%b %0d:%0d:%0d, want 1 0:1:0",
                     tick, hours, minutes, seconds);
        end else passed++;
        repeat (3) step();
        total++;
        if (o_number !== 24'd100) begin
            $display("FAIL up_number: got %0d, want 100", o_number);
        end else passed++;
    endtask

    task automatic test_wrap();
        run = 1'b1; count_down = 1'b0;
        do_load(23, 59, 59);
        repeat (4) step();
        total++;
        if (tick !== 1'b1 || expired !== 1'b0 || hours !== 8'd0 || minutes !== 8'd0
            || seconds !== 8'd0) begin
            $display("FAIL wrap_time: got tick=%b exp=%b %0d:%0d:%0d, want 1 0 0:0:0",
                     tick, expired, hours, minutes, seconds);
        end else passed++;
        repeat (2) step();
        total++;
        if (o_number !== 24'd235959) begin
            $display("FAIL wrap_number_before: got %0d, want 235959", o_number);
        end else passed++;
        step();
        total++;
        if (o_number !== 24'd0 || expired !== 1'b0) begin
            $display("FAIL wrap_number: got %0d exp=%b, want 0 0", o_number, expired);
        end else passed++;
    endtask

    task automatic test_countdown();
        bit found;
        run = 1'b1; count_down = 1'b1;
        do_load(0, 0, 2);
        repeat (4) step();
        total++;
        if (seconds !== 8'd1 || tick !== 1'b1 || expired !== 1'b0) begin
            $display("FAIL down_first: got s=%0d tick=%b exp=%b, want 1 1 0",
                     seconds, tick, expired);
        end else passed++;
        repeat (4) step();
        total++;
        if (seconds !== 8'd0 || expired !== 1'b1) begin
            $display("FAIL down_expire: got s=%0d exp=%b, want 0 1", seconds, expired);
        end else passed++;
        step();
        total++;
        if (expired !== 1'b0) begin
            $display("FAIL down_expire_width: got exp=%b, want 0", expired);
        end else passed++;
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (tick !== 1'b0 || expired !== 1'b0 || hours !== 8'd0 || minutes !== 8'd0
                || seconds !== 8'd0) begin
                $display("FAIL done_hold[%0d]: got tick=%b exp=%b %0d:%0d:%0d, want 0 0 0:0:0",
                         i, tick, expired, hours, minutes, seconds);
            end else passed++;
        end
        run = 1'b0;
        step();
        run = 1'b1; count_down = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (tick === 1'b1) found = 1;
        end
        total++;
        if (!found || seconds !== 8'd1) begin
            $display("FAIL done_to_idle: got tick_seen=%b s=%0d, want 1 1", found, seconds);
        end else passed++;
    endtask

    task automatic test_borrow();
        run = 1'b1; count_down = 1'b1;
        do_load(1, 0, 0);
        repeat (4) step();
        total++;
        if (hours !== 8'd0 || minutes !== 8'd59 || seconds !== 8'd59 || tick !== 1'b1) begin
            $display("FAIL borrow_time: got %0d:%0d:%0d tick=%b, want 0:59:59 1",
                     hours, minutes, seconds, tick);
        end else passed++;
        repeat (3) step();
        total++;
        if (o_number !== 24'd5959) begin
            $display("FAIL borrow_number: got %0d, want 5959", o_number);
        end else passed++;
    endtask

    task automatic test_adjust_hold();
        run = 1'b0; count_down = 1'b0;
        do_load(0, 59, 30);
        adjust_minutes = 1'b1;
        repeat (10) step();
        total++;
        if (hours !== 8'd0 || minutes !== 8'd0 || seconds !== 8'd30) begin
            $display("FAIL adjust_hold: got %0d:%0d:%0d, want 0:0:30", hours, minutes, seconds);
        end else passed++;
        adjust_minutes = 1'b0;
        step();
        adjust_hours = 1'b1;
        step();
        total++;
        if (hours !== 8'd1 || minutes !== 8'd0) begin
            $display("FAIL adjust_hours: got %0d:%0d, want 1:0", hours, minutes);
        end else passed++;
        adjust_hours = 1'b0;
        step();
        adjust_hours = 1'b1; adjust_minutes = 1'b1;
        step();
        total++;
        if (hours !== 8'd2 || minutes !== 8'd1 || seconds !== 8'd30) begin
            $display("FAIL adjust_both: got %0d:%0d:%0d, want 2:1:30", hours, minutes, seconds);
        end else passed++;
        adjust_hours = 1'b0; adjust_minutes = 1'b0;
        step();
    endtask

    task automatic test_adjust_on_tick();
        run = 1'b1; count_down = 1'b0;
        do_load(0, 10, 20);
        repeat (3) step();
        adjust_minutes = 1'b1;
        step();
        total++;
        if (minutes !== 8'd11 || seconds !== 8'd20 || tick !== 1'b0) begin
            $display("FAIL adj_tick_edge: got %0d:%0d tick=%b, want 11:20 0",
                     minutes, seconds, tick);
        end else passed++;
        step();
        total++;
        if (minutes !== 8'd11 || seconds !== 8'd21 || tick !== 1'b1) begin
            $display("FAIL adj_tick_pending: got %0d:%0d tick=%b, want 11:21 1",
                     minutes, seconds, tick);
        end else passed++;
        adjust_minutes = 1'b0;
        repeat (3) step();
        total++;
        if (seconds !== 8'd22 || tick !== 1'b1) begin
            $display("FAIL adj_tick_next: got s=%0d tick=%b, want 22 1", seconds, tick);
        end else passed++;
    endtask

    task automatic test_clamp();
        bit found;
        run = 1'b0; count_down = 1'b0;
        do_load(30, 75, 99);
        total++;
        if (h12 !== 8'd11 || m12 !== 8'd59 || s12 !== 8'd59) begin
            $display("FAIL clamp_12h: got %0d:%0d:%0d, want 11:59:59", h12, m12, s12);
        end else passed++;
        total++;
        if (hours !== 8'd23 || minutes !== 8'd59 || seconds !== 8'd59) begin
            $display("FAIL clamp_24h: got %0d:%0d:%0d, want 23:59:59", hours, minutes, seconds);
        end else passed++;
        run = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (tick12 === 1'b1) found = 1;
        end
        total++;
        if (!found || h12 !== 8'd0 || m12 !== 8'd0 || s12 !== 8'd0 || exp12 !== 1'b0) begin
            $display("FAIL wrap_12h: got seen=%b %0d:%0d:%0d exp=%b, want 1 0:0:0 0",
                     found, h12, m12, s12, exp12);
        end else passed++;
        repeat (3) step();
        total++;
        if (onum12 !== 24'd0) begin
            $display("FAIL wrap_12h_number: got %0d, want 0", onum12);
        end else passed++;
    endtask

    task automatic test_async_reset();
        run = 1'b1; count_down = 1'b0;
        do_load(5, 6, 7);
        repeat (5) step();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (hours !== 8'd0 || minutes !== 8'd0 || seconds !== 8'd0 || h12 !== 8'd0) begin
            $display("FAIL async_reset_time: got %0d:%0d:%0d, want 0:0:0",
                     hours, minutes, seconds);
        end else passed++;
        total++;
        if (tick !== 1'b0 || expired !== 1'b0 || o_number !== 24'd0) begin
            $display("FAIL async_reset_out: got tick=%b exp=%b n=%0d, want 0 0 0",
                     tick, expired, o_number);
        end else passed++;
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        int eh, em, es;
        run = 1'b1; count_down = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            load = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 1) begin
                load_h = 8'($urandom_range(0, 1));
                load_m = 8'($urandom_range(0, 1));
                load_s = 8'($urandom_range(0, 6));
            end else begin
                load_h = 8'($urandom); load_m = 8'($urandom); load_s = 8'($urandom);
            end
            if ($urandom_range(0, 149) == 0) run = ~run;
            if ($urandom_range(0, 79) == 0) count_down = ~count_down;
            if ($urandom_range(0, 19) == 0) adjust_minutes = ~adjust_minutes;
            if ($urandom_range(0, 29) == 0) adjust_hours = ~adjust_hours;
            step();
            eh = m_secs / 3600; em = (m_secs / 60) % 60; es = m_secs % 60;
            total++;
            if (hours !== 8'(eh) || minutes !== 8'(em) || seconds !== 8'(es)
                || tick !== m_tick || expired !== m_exp || o_number !== 24'(m_onum)) begin
                $display("FAIL random[%0d]: got %0d:%0d:%0d t=%b e=%b n=%0d, want %0d:%0d:%0d t=%b e=%b n=%0d",
                         i, hours, minutes, seconds, tick, expired, o_number,
                         eh, em, es, m_tick, m_exp, m_onum);
            end else passed++;
        end
        load = 1'b0; adjust_minutes = 1'b0; adjust_hours = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_count_up();
        test_wrap();
        test_countdown();
        test_borrow();
        test_adjust_hold();
        test_adjust_on_tick();
        test_clamp();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
                 passed, total);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hms_timer.md
# hms_timer

Parametrised hours/minutes/seconds timekeeper for the digital clock: counts up as a wall clock or down as a countdown timer, driven by an internal one-second prescaler. It supports preset loading, edge-triggered hour/minute adjustment and a configurable hour modulus (12/24). It feeds the display path with raw binary fields and a pipelined decimal-packed `hhmmss` number.

## Interface
- `T_HOLD`, 100_000_000, clock cycles per one-second tick (≥2).
- `T_HOLD_WIDTH`, $clog2(T_HOLD), prescaler width.
- `HOURS_MAX`, 24, hour modulus; legal range 2..100.
- `clk`  in  1  single system clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  level; 1 = time advances on ticks.
- `count_down`  in  1  level; 0 = count up, 1 = countdown.
- `adjust_minutes`  in  1  level; rising edge = minutes +1.
- `adjust_hours`  in  1  level; rising edge = hours +1.
- `load`  in  1  one-cycle strobe; load preset.
- `load_h`, `load_m`, `load_s`  in  8 each  preset values.
- `hours`, `minutes`, `seconds`  out  8 each  registered binary time.
- `tick`  out  1  one-cycle pulse; the cycle the advanced time first appears.
- `expired`  out  1  one-cycle pulse; countdown reached 00:00:00.
- `o_number`  out  24  hours·10000 + minutes·100 + seconds.

## Operation
- Reset: time 00:00:00, prescaler 0, FSM IDLE, pending-tick 0, edge-detector history 0, `tick`/`expired`/`o_number` 0. Takes effect immediately, without a clock edge.
- Prescaler: free-running 0..T_HOLD-1. Internal tick when it equals T_HOLD-1, then wraps to 0. Cleared by `load`.
- FSM states:
  - IDLE → COUNT when `run`=1.
  - COUNT → IDLE when `run`=0.
  - COUNT → DONE on a countdown tick at zero time, or on a decrement reaching zero.
  - DONE → IDLE when `run`=0 or `load`.
  - `load` with `run`=1 → COUNT.
- Internal ticks are consumed only in COUNT. Ticks are discarded in IDLE and DONE.
- Count up:
  - s 59→0 carries into m.
  - m 59→0 carries into h.
  - h HOURS_MAX-1→0 wraps; no flag.
- Count down:
  - s 0→59 borrows from m.
  - m 0→59 borrows from h.
  - Decrement from 00:00:01 → 00:00:00 asserts `expired` and enters DONE.
  - A tick with time already zero enters DONE with no `expired` and no time change.
- Adjust:
  - Each rising edge adds 1 to its field, in either mode and any state.
  - Minutes wrap 59→0 without carry into hours.
  - Hours wrap HOURS_MAX-1→0.
  - Held-high inputs produce exactly one step.
  - Both adjust edges in one cycle: both applied.
- Priority: `rst` > `load` > adjust > tick.
  - A tick coinciding with an adjust edge is held in the pending flag and applied the next cycle; no tick is lost.
  - A tick coinciding with `load` is dropped.
- Load clamp: values above range clamp to the maximum (h→HOURS_MAX-1, m/s→59).
- `count_down` changes take effect at the next applied tick.

## Timing
- Time registers update on the edge where the tick is applied. `tick`/`expired` are high for exactly the following cycle, aligned with the new `hours`/`minutes`/`seconds`.
- Pending tick: applied one cycle later; `tick` is delayed accordingly.
- `load`/adjust: fields update on the sampling edge; visible the next cycle.
- `o_number` pipeline, 3-cycle latency from the time registers, no reset-dependent bubbles after the first 3 cycles:
  - Stage 1: h·100, m·100, s.
  - Stage 2: (h·100)·100, and m·100 + s.
  - Stage 3: sum.
- Width: maximum 99·10000 + 5959 = 995959 < 2^20; upper `o_number` bits are always 0.
- Period: one applied tick every T_HOLD cycles in steady COUNT.

## Test plan
- Basic count up: T_HOLD=4, load 00:00:58, `run`=1, count up. Two ticks, 8 cycles apart after load → 00:01:00 with `tick` pulses; `o_number`=100 three cycles after the second `tick`.
- Wrap: HOURS_MAX=24, load 23:59:59, count up. One tick → 00:00:00, `o_number`=0, `expired` stays 0.
- Countdown expiry: load 00:00:02, `count_down`=1. Ticks give 00:00:01, then 00:00:00 with a single `expired` pulse and DONE. Further T_HOLD periods leave time 0 with no `tick`/`expired`. `run`=0 returns to IDLE.
- Borrow: load 01:00:00, countdown → 00:59:59 after one tick; `o_number`=5959.
- Adjust:
  - At 00:59:30, `adjust_minutes` held 10 cycles → 00:00:30 (one step, hours unchanged).
  - Adjust edge on the tick cycle → minutes +1 and seconds +1 one cycle later; `tick` delayed one cycle.
- Load clamp and async reset:
  - HOURS_MAX=12, load 30:75:99 → 11:59:59.
  - `rst` asserted mid-COUNT between edges → all outputs 0 before the next posedge.
